// File: rtl/kf8259_in_service_control.sv
// kf8259_in_service_control: 8259 ISR, INTA acknowledge sequencing, EOI and priority rotation.
// Optional poll mode is enabled with `define KF8259_POLL_EN.
module kf8259_in_service_control #(
    parameter logic [2:0]  SPURIOUS_LEVEL = 3'd7,
    parameter int unsigned ACK_TIMEOUT    = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt,
    input  logic       ack_start,
    input  logic       ack_end,
    input  logic       auto_eoi_config,
    input  logic       rotate_in_auto_eoi,
    input  logic       eoi_nonspecific,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       rotate_on_eoi,
    input  logic       set_priority,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic [2:0] priority_rotate,
    output logic [2:0] acknowledged_level,
    output logic [7:0] clear_interrupt_request,
    output logic       ack_active
`ifdef KF8259_POLL_EN
    ,
    input  logic       poll_command,
    output logic [7:0] poll_word
`endif
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t      state, state_next;
    logic [15:0] count;
    logic        spurious;
    logic        poll_go, ack_go, ack_done, timeout, winner;
    logic [7:0]  isr_set, eoi_clr, aeoi_clr, isr_next;
    logic [2:0]  rotate_next;

    function automatic logic [2:0] encode(input logic [7:0] v);
        encode = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) encode = 3'(i);
    endfunction

`ifdef KF8259_POLL_EN
    assign poll_go = poll_command && state == IDLE;
`else
    assign poll_go = 1'b0;
`endif

    assign winner     = |interrupt;
    assign ack_go     = state == IDLE && (ack_start || poll_go);
    assign ack_done   = state == ACK && ack_end;
    assign timeout    = ACK_TIMEOUT != 0 && state == ACK && count == 16'(ACK_TIMEOUT - 1);
    assign ack_active = state == ACK;
    assign isr_set    = ack_go ? interrupt : 8'd0;
    assign aeoi_clr   = (ack_done && auto_eoi_config && !spurious) ? 8'd1 << acknowledged_level : 8'd0;
    assign eoi_clr    = eoi_specific ? 8'd1 << eoi_level : eoi_nonspecific ? highest_level_in_service : 8'd0;
    // A same-cycle set overrides any clear of the same bit.
    assign isr_next   = (in_service_register & ~(aeoi_clr | eoi_clr)) | isr_set;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        highest_level_in_service = 8'd0;
        for (int i = 7; i >= 0; i--)
            if (in_service_register[3'(priority_rotate + 3'(i) + 3'd1)])
                highest_level_in_service = 8'd1 << 3'(priority_rotate + 3'(i) + 3'd1);
    end

    always_comb begin
        rotate_next = set_priority ? eoi_level :
                      (rotate_on_eoi && |eoi_clr) ? encode(eoi_clr) :
                      (rotate_in_auto_eoi && |aeoi_clr) ? acknowledged_level : priority_rotate;
        state_next  = state == IDLE ? ((ack_go && !poll_go) ? ACK : IDLE) :
                      ((ack_done || timeout) ? IDLE : ACK);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            count                   <= 16'd0;
            spurious                <= 1'b0;
            in_service_register     <= 8'd0;
            clear_interrupt_request <= 8'd0;
            priority_rotate         <= 3'b111;
            acknowledged_level      <= 3'd0;
        end else begin
            state                   <= state_next;
            count                   <= (state == ACK && state_next == ACK) ? count + 16'd1 : 16'd0;
            in_service_register     <= isr_next;
            clear_interrupt_request <= isr_set;
            priority_rotate         <= rotate_next;
            if (ack_go) begin
                acknowledged_level <= winner ? encode(interrupt) : SPURIOUS_LEVEL;
                spurious           <= !winner;
            end
        end
    end

`ifdef KF8259_POLL_EN
    always_ff @(posedge clock) begin
        if (reset)
            poll_word <= 8'd0;
        else if (poll_go)
            poll_word <= {winner, 4'b0, winner ? encode(interrupt) : 3'd0};
    end
`endif

endmodule

// File: tb/tb_kf8259_in_service_control.sv
// tb_kf8259_in_service_control: directed checks of ack sequencing, EOI, rotation and timeout.
module tb_kf8259_in_service_control;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] interrupt = 8'd0;
    logic       ack_start = 1'b0, ack_end = 1'b0;
    logic       auto_eoi_config = 1'b0, rotate_in_auto_eoi = 1'b0;
    logic       eoi_nonspecific = 1'b0, eoi_specific = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic       rotate_on_eoi = 1'b0, set_priority = 1'b0;
    logic [7:0] in_service_register, highest_level_in_service, clear_interrupt_request;
    logic [2:0] priority_rotate, acknowledged_level;
    logic       ack_active;
`ifdef KF8259_POLL_EN
    logic       poll_command = 1'b0;
    logic [7:0] poll_word;
`endif

    int errors = 0;
    int checks = 0;

    kf8259_in_service_control #(.SPURIOUS_LEVEL(3'd7), .ACK_TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .interrupt(interrupt),
        .ack_start(ack_start), .ack_end(ack_end),
        .auto_eoi_config(auto_eoi_config), .rotate_in_auto_eoi(rotate_in_auto_eoi),
        .eoi_nonspecific(eoi_nonspecific), .eoi_specific(eoi_specific),
        .eoi_level(eoi_level), .rotate_on_eoi(rotate_on_eoi), .set_priority(set_priority),
        .in_service_register(in_service_register),
        .highest_level_in_service(highest_level_in_service),
        .priority_rotate(priority_rotate), .acknowledged_level(acknowledged_level),
        .clear_interrupt_request(clear_interrupt_request), .ack_active(ack_active)
`ifdef KF8259_POLL_EN
        , .poll_command(poll_command), .poll_word(poll_word)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        tick; tick;
        reset = 1'b0;
        tick;
        check("reset_isr", in_service_register, 8'h00);
        check("reset_rot", 8'(priority_rotate), 8'd7);
        check("reset_active", 8'(ack_active), 8'd0);
        check("reset_clr", clear_interrupt_request, 8'h00);
        check("reset_hl", highest_level_in_service, 8'h00);

        // normal acknowledge of IR3
        interrupt = 8'h08; ack_start = 1'b1; tick; ack_start = 1'b0;
        check("ack_isr", in_service_register, 8'h08);
        check("ack_clr", clear_interrupt_request, 8'h08);
        check("ack_level", 8'(acknowledged_level), 8'd3);
        check("ack_active", 8'(ack_active), 8'd1);
        check("ack_hl", highest_level_in_service, 8'h08);
        tick;
        check("ack_clr_gone", clear_interrupt_request, 8'h00);
        ack_end = 1'b1; tick; ack_end = 1'b0;
        check("ack_end_active", 8'(ack_active), 8'd0);
        check("ack_end_isr", in_service_register, 8'h08);

        // spurious acknowledge, AEOI must not touch the ISR
        interrupt = 8'h00; ack_start = 1'b1; tick; ack_start = 1'b0;
        check("spur_level", 8'(acknowledged_level), 8'd7);
        check("spur_isr", in_service_register, 8'h08);
        check("spur_clr", clear_interrupt_request, 8'h00);
        check("spur_active", 8'(ack_active), 8'd1);
        auto_eoi_config = 1'b1; ack_end = 1'b1; tick; ack_end = 1'b0; auto_eoi_config = 1'b0;
        check("spur_end_isr", in_service_register, 8'h08);
        check("spur_end_active", 8'(ack_active), 8'd0);

        // specific EOI of IR3
        eoi_specific = 1'b1; eoi_level = 3'd3; tick; eoi_specific = 1'b0;
        check("seoi_isr", in_service_register, 8'h00);
        check("seoi_rot", 8'(priority_rotate), 8'd7);

        // set priority to 0, then build ISR=81
        set_priority = 1'b1; eoi_level = 3'd0; tick; set_priority = 1'b0;
        check("setpri_rot", 8'(priority_rotate), 8'd0);
        interrupt = 8'h01; ack_start = 1'b1; tick; ack_start = 1'b0;
        ack_end = 1'b1; tick; ack_end = 1'b0;
        interrupt = 8'h80; ack_start = 1'b1; tick; ack_start = 1'b0;
        ack_end = 1'b1; tick; ack_end = 1'b0;
        check("rot_isr", in_service_register, 8'h81);
        check("rot_hl", highest_level_in_service, 8'h80);
        eoi_nonspecific = 1'b1; rotate_on_eoi = 1'b1; tick; eoi_nonspecific = 1'b0; rotate_on_eoi = 1'b0;
        check("rot_eoi_isr", in_service_register, 8'h01);
        check("rot_eoi_rot", 8'(priority_rotate), 8'd7);
        check("rot_eoi_hl", highest_level_in_service, 8'h01);

        // non-specific EOI with empty ISR must not rotate
        eoi_nonspecific = 1'b1; tick;
        check("nseoi_isr", in_service_register, 8'h00);
        rotate_on_eoi = 1'b1; tick; eoi_nonspecific = 1'b0; rotate_on_eoi = 1'b0;
        check("nseoi_empty_rot", 8'(priority_rotate), 8'd7);

        // EOI and ack_start on the same level: set wins
        interrupt = 8'h10; ack_start = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd4; tick;
        ack_start = 1'b0; eoi_specific = 1'b0;
        check("same_lvl_isr", in_service_register, 8'h10);
        ack_end = 1'b1; tick; ack_end = 1'b0;
        // different levels: both apply
        interrupt = 8'h02; ack_start = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd4; tick;
        ack_start = 1'b0; eoi_specific = 1'b0;
        check("diff_lvl_isr", in_service_register, 8'h02);
        ack_end = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd1; tick; ack_end = 1'b0; eoi_specific = 1'b0;
        check("diff_clear_isr", in_service_register, 8'h00);

        // AEOI with rotation on IR5
        auto_eoi_config = 1'b1; rotate_in_auto_eoi = 1'b1;
        interrupt = 8'h20; ack_start = 1'b1; tick; ack_start = 1'b0;
        check("aeoi_set_isr", in_service_register, 8'h20);
        ack_end = 1'b1; tick; ack_end = 1'b0;
        check("aeoi_isr", in_service_register, 8'h00);
        check("aeoi_rot", 8'(priority_rotate), 8'd5);

        // timeout: no ack_end, ACK for exactly 4 clocks
        ack_start = 1'b1; tick; ack_start = 1'b0;
        check("to_active0", 8'(ack_active), 8'd1);
        tick; tick; tick;
        check("to_active3", 8'(ack_active), 8'd1);
        tick;
        check("to_idle", 8'(ack_active), 8'd0);
        check("to_isr", in_service_register, 8'h20);
        // ack_end in IDLE is ignored
        ack_end = 1'b1; tick; ack_end = 1'b0;
        check("idle_end_isr", in_service_register, 8'h20);
        check("idle_end_rot", 8'(priority_rotate), 8'd5);
        auto_eoi_config = 1'b0; rotate_in_auto_eoi = 1'b0;

`ifdef KF8259_POLL_EN
        interrupt = 8'h04; poll_command = 1'b1; tick; poll_command = 1'b0;
        check("poll_word", poll_word, 8'h82);
        check("poll_isr", in_service_register, 8'h24);
        check("poll_active", 8'(ack_active), 8'd0);
        interrupt = 8'h00; poll_command = 1'b1; tick; poll_command = 1'b0;
        check("poll_none", poll_word, 8'h00);
`endif

        // reset mid-sequence aborts and discards pulses
        interrupt = 8'h01; ack_start = 1'b1; tick; ack_start = 1'b0;
        check("mid_active", 8'(ack_active), 8'd1);
        reset = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2; set_priority = 1'b1; tick;
        reset = 1'b0; eoi_specific = 1'b0; set_priority = 1'b0;
        check("rst_isr", in_service_register, 8'h00);
        check("rst_rot", 8'(priority_rotate), 8'd7);
        check("rst_active", 8'(ack_active), 8'd0);
        check("rst_level", 8'(acknowledged_level), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
